// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter: priority state,
// requester id and the read-tag entry carried alongside the RAM latency.
package ram_arb_pkg;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam int unsigned NUM_REQ = 2;

  // Whoever just won yields the tie-break to the other requester.
  function automatic pri_state_e pri_after_grant(input req_id_t id);
    return (id == 1'b0) ? PRI1 : PRI0;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register of read tags; stage DEPTH-1 lines up with the
// RAM read data for the command that produced the tag.
module tag_delay_line
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_a_rst_n,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t [DEPTH-1:0] tag_pipe;

  // Clearing every stage on reset discards reads that were in flight.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe <= {tag_pipe[DEPTH-2:0], i_tag};
    end
  end

  assign o_tag = tag_pipe[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between two valid/ready requesters with alternating
// tie-break priority; read data is routed back using a latency-matched tag.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_a_rst_n,
  input  logic                  i_req_valid_0,
  input  logic                  i_req_valid_1,
  output logic                  o_req_ready_0,
  output logic                  o_req_ready_1,
  input  logic                  i_req_wr_0,
  input  logic                  i_req_wr_1,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
  input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
  input  logic [DATA_WIDTH-1:0] i_req_data_0,
  input  logic [DATA_WIDTH-1:0] i_req_data_1,
  output logic                  o_rsp_valid_0,
  output logic                  o_rsp_valid_1,
  output logic [DATA_WIDTH-1:0] o_rsp_data_0,
  output logic [DATA_WIDTH-1:0] o_rsp_data_1,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  input  logic [DATA_WIDTH-1:0] i_ram_data
);

  localparam int unsigned TAG_DEPTH = 1 + RD_LATENCY;

  pri_state_e state_q, state_d;
  logic       gnt_0, gnt_1;
  logic       xfer;
  req_id_t    xfer_id;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  ram_wr_en_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_q;
  tag_t                  tag_in, tag_out;

  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      state_q <= PRI0;
    end else begin
      state_q <= state_d;
    end
  end

  // Ready only goes to a valid requester, so ready doubles as the grant;
  // holding both low during reset keeps any handshake from completing.
  always_comb begin
    gnt_0   = 1'b0;
    gnt_1   = 1'b0;
    state_d = state_q;
    if (i_a_rst_n) begin
      if (i_req_valid_0 && (!i_req_valid_1 || state_q == PRI0)) begin
        gnt_0 = 1'b1;
      end else if (i_req_valid_1) begin
        gnt_1 = 1'b1;
      end
    end
    if (gnt_0) begin
      state_d = pri_after_grant(1'b0);
    end else if (gnt_1) begin
      state_d = pri_after_grant(1'b1);
    end
  end

  assign o_req_ready_0 = gnt_0;
  assign o_req_ready_1 = gnt_1;
  assign xfer          = gnt_0 | gnt_1;
  assign xfer_id       = gnt_1;

  always_comb begin
    sel_wr   = i_req_wr_0;
    sel_addr = i_req_addr_0;
    sel_data = i_req_data_0;
    if (xfer_id) begin
      sel_wr   = i_req_wr_1;
      sel_addr = i_req_addr_1;
      sel_data = i_req_data_1;
    end
  end

  // Address and data hold between commands; only the write strobe drops.
  always_ff @(posedge i_clk or negedge i_a_rst_n) begin
    if (!i_a_rst_n) begin
      ram_wr_en_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      ram_wr_en_q <= xfer && sel_wr;
      if (xfer) begin
        ram_addr_q <= sel_addr;
        ram_data_q <= sel_data;
      end
    end
  end

  assign o_ram_wr_en = ram_wr_en_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_data  = ram_data_q;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = xfer && !sel_wr;
    tag_in.id    = xfer_id;
  end

  tag_delay_line #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_delay_line (
    .i_clk     (i_clk),
    .i_a_rst_n (i_a_rst_n),
    .i_tag     (tag_in),
    .o_tag     (tag_out)
  );

  assign o_rsp_valid_0 = tag_out.valid && (tag_out.id == 1'b0);
  assign o_rsp_valid_1 = tag_out.valid && (tag_out.id == 1'b1);
  assign o_rsp_data_0  = o_rsp_valid_0 ? i_ram_data : '0;
  assign o_rsp_data_1  = o_rsp_valid_1 ? i_ram_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized + directed bench for ram_port_arbiter against a queue-based
// reference model; a second instance covers the single-cycle RAM latency.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RD_LATENCY = 2) ----------------
  logic       v [2];
  logic       wr [2];
  logic [7:0] addr [2];
  logic [7:0] wdat [2];
  logic       rdy0, rdy1, rv0, rv1;
  logic [7:0] rd0, rd1;
  logic       ram_we;
  logic [7:0] ram_a, ram_wd, ram_rd;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(2)) dut (
    .i_clk(clk), .i_a_rst_n(rst_n),
    .i_req_valid_0(v[0]), .i_req_valid_1(v[1]),
    .o_req_ready_0(rdy0), .o_req_ready_1(rdy1),
    .i_req_wr_0(wr[0]), .i_req_wr_1(wr[1]),
    .i_req_addr_0(addr[0]), .i_req_addr_1(addr[1]),
    .i_req_data_0(wdat[0]), .i_req_data_1(wdat[1]),
    .o_rsp_valid_0(rv0), .o_rsp_valid_1(rv1),
    .o_rsp_data_0(rd0), .o_rsp_data_1(rd1),
    .o_ram_wr_en(ram_we), .o_ram_addr(ram_a), .o_ram_data(ram_wd),
    .i_ram_data(ram_rd)
  );

  // RAM with 2-cycle read latency
  logic [7:0] ram_h [256] = '{default: 8'h00};
  logic [7:0] rdp_h [2];
  always @(posedge clk) begin
    if (ram_we) ram_h[ram_a] <= ram_wd;
    rdp_h[0] <= ram_h[ram_a];
    rdp_h[1] <= rdp_h[0];
  end
  assign ram_rd = rdp_h[1];

  // ---------------- low-latency DUT (RD_LATENCY = 1) ----------------
  logic       lv0 = 1'b0, lv1 = 1'b0, lwr0 = 1'b0, lwr1 = 1'b0;
  logic [7:0] la0 = '0, la1 = '0, ld0 = '0, ld1 = '0;
  logic       lrdy0, lrdy1, lrv0, lrv1;
  logic [7:0] lrd0, lrd1;
  logic       lram_we;
  logic [7:0] lram_a, lram_wd, lram_rd;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(1)) dut_l (
    .i_clk(clk), .i_a_rst_n(rst_n),
    .i_req_valid_0(lv0), .i_req_valid_1(lv1),
    .o_req_ready_0(lrdy0), .o_req_ready_1(lrdy1),
    .i_req_wr_0(lwr0), .i_req_wr_1(lwr1),
    .i_req_addr_0(la0), .i_req_addr_1(la1),
    .i_req_data_0(ld0), .i_req_data_1(ld1),
    .o_rsp_valid_0(lrv0), .o_rsp_valid_1(lrv1),
    .o_rsp_data_0(lrd0), .o_rsp_data_1(lrd1),
    .o_ram_wr_en(lram_we), .o_ram_addr(lram_a), .o_ram_data(lram_wd),
    .i_ram_data(lram_rd)
  );

  logic [7:0] ram_l [256] = '{default: 8'h00};
  logic [7:0] rdp_l;
  always @(posedge clk) begin
    if (lram_we) ram_l[lram_a] <= lram_wd;
    rdp_l <= ram_l[lram_a];
  end
  assign lram_rd = rdp_l;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    int         due;
    logic [7:0] d;
  } exp_rsp_t;

  exp_rsp_t   rsp_q[$];
  logic [7:0] mem [256];
  int         tie_winner;       // requester that wins when both are valid
  logic       exp_we;
  logic [7:0] exp_a, exp_wd;
  int         cyc;
  int         obs_gnt;
  int         wait_cnt [2];
  int         rsp_cyc [2];
  logic [7:0] rsp_last [2];
  int         rsp_cnt [2];

  // One clock of the main DUT: check at negedge, then advance the model.
  task automatic step();
    int         eg;
    logic       ev [2];
    logic [7:0] ed [2];
    @(negedge clk);
    eg = -1;
    if (v[0] && v[1]) eg = tie_winner;
    else if (v[0])    eg = 0;
    else if (v[1])    eg = 1;
    chk("ready_0", rdy0, eg == 0);
    chk("ready_1", rdy1, eg == 1);
    obs_gnt = rdy1 ? 1 : (rdy0 ? 0 : -1);

    ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      ev[rsp_q[0].id] = 1'b1;
      ed[rsp_q[0].id] = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end
    chk("rsp_valid_0", rv0, ev[0]);
    chk("rsp_data_0",  rd0, ed[0]);
    chk("rsp_valid_1", rv1, ev[1]);
    chk("rsp_data_1",  rd1, ed[1]);
    chk("ram_wr_en",   ram_we, exp_we);
    chk("ram_addr",    ram_a,  exp_a);
    chk("ram_data",    ram_wd, exp_wd);

    if (rv0) begin rsp_cyc[0] = cyc; rsp_last[0] = rd0; rsp_cnt[0]++; end
    if (rv1) begin rsp_cyc[1] = cyc; rsp_last[1] = rd1; rsp_cnt[1]++; end

    for (int n = 0; n < 2; n++) begin
      if (v[n] && !(obs_gnt == n)) begin
        wait_cnt[n]++;
        if (wait_cnt[n] > 1) chk("hold_starved", wait_cnt[n], 1);
      end else begin
        wait_cnt[n] = 0;
      end
    end

    exp_we = 1'b0;
    if (eg >= 0) begin
      exp_we = wr[eg];
      exp_a  = addr[eg];
      exp_wd = wdat[eg];
      if (wr[eg]) mem[addr[eg]] = wdat[eg];
      else        rsp_q.push_back('{id: eg, due: cyc + 3, d: mem[addr[eg]]});
      tie_winner = 1 - eg;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    rsp_q.delete();
    tie_winner = 0;
    exp_we = 1'b0;
    exp_a  = '0;
    exp_wd = '0;
    wait_cnt[0] = 0; wait_cnt[1] = 0;
  endtask

  task automatic set_req(input int n, input logic val, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    v[n] = val; wr[n] = w; addr[n] = a; wdat[n] = d;
  endtask

  task automatic idle(input int k);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < k; i++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd_cyc;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h00, 8'h00);
    model_reset();
    cyc = 0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;

    // Reset held with both requesters valid: nothing may be accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_0", rdy0, 1'b0);
    chk("rst_ready_1", rdy1, 1'b0);
    chk("rst_ram_we",  ram_we, 1'b0);
    chk("rst_ram_a",   ram_a, 8'h00);
    chk("rst_ram_wd",  ram_wd, 8'h00);
    chk("rst_rsp_v0",  rv0, 1'b0);
    chk("rst_rsp_d1",  rd1, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention from reset: strict alternation starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, 1'b0, 8'(8'h40 + i), 8'h00);
      set_req(1, 1'b1, 1'b0, 8'(8'h80 + i), 8'h00);
      step();
      chk("s2_grant_order", obs_gnt, i % 2);
    end
    idle(4);

    // Single requester write then read.
    rsp_cnt[1] = 0;
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    step();
    set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
    rd_cyc = cyc;
    step();
    idle(5);
    chk("s1_rsp_data", rsp_last[0], 8'hA5);
    chk("s1_rsp_latency", rsp_cyc[0] - rd_cyc, 3);
    chk("s1_no_rsp_1", rsp_cnt[1], 0);

    // Interleaved reads from both requesters.
    set_req(0, 1'b1, 1'b1, 8'h01, 8'h11); step();
    set_req(0, 1'b1, 1'b1, 8'h02, 8'h22); step();
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00); step();
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00); step();
    idle(5);
    chk("s3_rsp0", rsp_last[0], 8'h11);
    chk("s3_rsp1", rsp_last[1], 8'h22);
    chk("s3_gap", rsp_cyc[1] - rsp_cyc[0], 1);

    // Randomized traffic: requests held until accepted.
    idle(1);
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && ($urandom_range(2) != 0))
          set_req(n, 1'b1, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
      end
      step();
      for (int n = 0; n < 2; n++) if (obs_gnt == n) v[n] = 1'b0;
    end
    idle(5);
    chk("rand_drained", rsp_q.size(), 0);

    // Reset pulse with two reads in flight.
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_0", rdy0, 1'b0);
    chk("mid_rst_ready_1", rdy1, 1'b0);
    chk("mid_rst_ram_a", ram_a, 8'h00);
    chk("mid_rst_rsp_v", {rv0, rv1}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    idle(6);
    chk("post_rst_no_rsp", rsp_cnt[0] + rsp_cnt[1], 0);
    set_req(0, 1'b1, 1'b0, 8'h03, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h04, 8'h00);
    step();
    chk("post_rst_pri0", obs_gnt, 0);
    idle(5);

    // Low-latency RAM: read-after-write to the last address.
    lv1 = 1'b1; lwr1 = 1'b1; la1 = 8'hFF; ld1 = 8'h3C;
    @(negedge clk);
    chk("s5_wr_ready", lrdy1, 1'b1);
    @(posedge clk); #1;
    lv1 = 1'b0; lwr1 = 1'b0;
    lv0 = 1'b1; lwr0 = 1'b0; la0 = 8'hFF;
    @(negedge clk);
    chk("s5_rd_ready", lrdy0, 1'b1);
    @(posedge clk); #1;
    lv0 = 1'b0;
    @(negedge clk);
    chk("s5_early_v", lrv0, 1'b0);
    @(negedge clk);
    chk("s5_rsp_v", lrv0, 1'b1);
    chk("s5_rsp_d", lrd0, 8'h3C);
    chk("s5_rsp1_v", lrv1, 1'b0);
    @(negedge clk);
    chk("s5_pulse_end", lrv0, 1'b0);
    chk("s5_data_zero", lrd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
